// File: rtl/redmule_ctx_scheduler.sv
// Job front-end: stages a GEMM job, derives tiling on commit and queues it in a NumCtx-deep FWFT FIFO.
// Latency 18 cycles from commit to job_valid_o; commit_ready_o is low while calculating or while the FIFO is full.
module redmule_ctx_scheduler #(
    parameter int unsigned NumCtx      = 2,
    parameter int unsigned ArrayHeight = 4,
    parameter int unsigned PipeRegs    = 1,
    parameter int unsigned KTile       = 8,
    parameter int unsigned AddrW       = 32,
    localparam int unsigned CntW       = $clog2(NumCtx + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               reg_we_i,
    input  logic [2:0]         reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    input  logic               commit_i,
    output logic               commit_ready_o,
    output logic               busy_o,
    output logic               err_o,
    output logic [CntW-1:0]    ctx_cnt_o,
    output logic               job_valid_o,
    input  logic               job_ready_i,
    output logic [3*AddrW-1:0] job_addr_o,
    output logic [47:0]        job_size_o,
    output logic [5:0]         job_cfg_o,
    output logic [63:0]        job_iters_o,
    output logic [25:0]        job_lftovr_o
);

    localparam int unsigned ArrayWidth = ArrayHeight * PipeRegs;
    localparam int unsigned MT         = $clog2(ArrayWidth);
    localparam int unsigned NT         = $clog2(ArrayHeight);
    localparam int unsigned KT         = $clog2(KTile);
    localparam int unsigned PtrW       = (NumCtx > 1) ? $clog2(NumCtx) : 1;

    typedef struct packed {
        logic [AddrW-1:0] z;
        logic [AddrW-1:0] w;
        logic [AddrW-1:0] x;
        logic [15:0]      k;
        logic [15:0]      n;
        logic [15:0]      m;
        logic [2:0]       op;
        logic [2:0]       fmt;
        logic [15:0]      tot_stores;
        logic [15:0]      k_iter;
        logic [15:0]      n_iter;
        logic [15:0]      m_iter;
        logic             n_small;
        logic             k_small;
        logic [7:0]       m_lft;
        logic [7:0]       n_lft;
        logic [7:0]       k_lft;
    } ctx_t;

    typedef enum logic [1:0] {IDLE, CALC, MUL, PUSH} state_e;

    state_e           state_q, state_d;
    logic [3:0]       mul_cnt_q;
    logic             err_q, err_d;
    logic             snap, push, pop;
    logic [AddrW-1:0] x_q, w_q, z_q;
    logic [15:0]      m_q, n_q, k_q;
    logic [2:0]       op_q, fmt_q;
    ctx_t             job_q;
    logic [15:0]      mcand_q, mplier_q;
    logic [15:0]      m_iter, n_iter, k_iter;
    logic             size_zero;
    ctx_t             mem_q [NumCtx];
    ctx_t             head;
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(NumCtx - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q <= '0; w_q <= '0; z_q <= '0;
            m_q <= '0; n_q <= '0; k_q <= '0;
            op_q <= '0; fmt_q <= '0;
        end else if (reg_we_i) begin
            case (reg_addr_i)
                3'd0: x_q <= AddrW'(reg_wdata_i);
                3'd1: w_q <= AddrW'(reg_wdata_i);
                3'd2: z_q <= AddrW'(reg_wdata_i);
                3'd3: begin m_q <= reg_wdata_i[15:0]; k_q <= reg_wdata_i[31:16]; end
                3'd4: n_q <= reg_wdata_i[15:0];
                3'd5: begin op_q <= reg_wdata_i[12:10]; fmt_q <= reg_wdata_i[9:7]; end
                default: ;
            endcase
        end
    end

    // Ceiling division by the tile size: whole tiles plus one partial tile if any remainder.
    assign m_iter    = (job_q.m >> MT) + 16'(|job_q.m[MT-1:0]);
    assign n_iter    = (job_q.n >> NT) + 16'(|job_q.n[NT-1:0]);
    assign k_iter    = (job_q.k >> KT) + 16'(|job_q.k[KT-1:0]);
    assign size_zero = (job_q.m == '0) || (job_q.n == '0) || (job_q.k == '0);

    always_ff @(posedge clk_i) begin
        if (snap) begin
            job_q.x <= x_q; job_q.w <= w_q; job_q.z <= z_q;
            job_q.m <= m_q; job_q.n <= n_q; job_q.k <= k_q;
            job_q.op <= op_q; job_q.fmt <= fmt_q;
        end
        if (state_q == CALC) begin
            job_q.m_iter     <= m_iter;
            job_q.n_iter     <= n_iter;
            job_q.k_iter     <= k_iter;
            job_q.m_lft      <= 8'(job_q.m[MT-1:0]);
            job_q.n_lft      <= 8'(job_q.n[NT-1:0]);
            job_q.k_lft      <= 8'(job_q.k[KT-1:0]);
            job_q.n_small    <= job_q.n < 16'(ArrayHeight);
            job_q.k_small    <= job_q.k < 16'(KTile);
            job_q.tot_stores <= '0;
            mcand_q          <= m_iter;
            mplier_q         <= k_iter;
        end
        if (state_q == MUL) begin
            if (mplier_q[0]) job_q.tot_stores <= job_q.tot_stores + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            mul_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= (state_q == MUL) ? mul_cnt_q + 4'd1 : '0;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        snap    = 1'b0;
        push    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (commit_i && commit_ready_o) begin
                snap    = 1'b1;
                state_d = CALC;
            end
            CALC: if (size_zero) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = MUL;
            end
            MUL:  if (mul_cnt_q == 4'd15) state_d = PUSH;
            PUSH: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop = job_valid_o && job_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= job_q;
    end

    assign head           = mem_q[rd_ptr_q];
    assign commit_ready_o = (state_q == IDLE) && (cnt_q < CntW'(NumCtx));
    assign busy_o         = (state_q != IDLE);
    assign err_o          = err_q;
    assign ctx_cnt_o      = cnt_q;
    assign job_valid_o    = (cnt_q != '0);
    assign job_addr_o     = {head.z, head.w, head.x};
    assign job_size_o     = {head.k, head.n, head.m};
    assign job_cfg_o      = {head.op, head.fmt};
    assign job_iters_o    = {head.tot_stores, head.k_iter, head.n_iter, head.m_iter};
    assign job_lftovr_o   = {head.n_small, head.k_small, head.m_lft, head.n_lft, head.k_lft};

endmodule

// File: tb/tb_redmule_ctx_scheduler.sv
// Directed and randomized checks of redmule_ctx_scheduler against a queue-based job model.
module tb_redmule_ctx_scheduler;

    logic        clk = 1'b0;
    logic        rst_i, reg_we_i, commit_i, job_ready_i;
    logic [2:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic        commit_ready_o, busy_o, err_o, job_valid_o;
    logic [1:0]  ctx_cnt_o;
    logic [95:0] job_addr_o;
    logic [47:0] job_size_o;
    logic [5:0]  job_cfg_o;
    logic [63:0] job_iters_o;
    logic [25:0] job_lftovr_o;

    always #5 clk = ~clk;

    redmule_ctx_scheduler dut (
        .clk_i(clk), .rst_i(rst_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
        .reg_wdata_i(reg_wdata_i), .commit_i(commit_i), .commit_ready_o(commit_ready_o),
        .busy_o(busy_o), .err_o(err_o), .ctx_cnt_o(ctx_cnt_o), .job_valid_o(job_valid_o),
        .job_ready_i(job_ready_i), .job_addr_o(job_addr_o), .job_size_o(job_size_o),
        .job_cfg_o(job_cfg_o), .job_iters_o(job_iters_o), .job_lftovr_o(job_lftovr_o)
    );

    typedef struct {
        logic [95:0] addr;
        logic [47:0] size;
        logic [5:0]  cfg;
        logic [63:0] iters;
        logic [25:0] lft;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0, bad = 0, err_seen = 0;
    bit          auto_pop = 1'b0;
    logic [31:0] st_x, st_w, st_z;
    int          st_m, st_n, st_k, st_op, st_fmt;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Tiles: M by 4, N by 4, K by 8; products wrap at 16 bits.
    function automatic exp_t model(input logic [31:0] x, w, z, input int m, n, k, op, fmt);
        exp_t e;
        int mi, ni, ki;
        mi = (m + 3) / 4;
        ni = (n + 3) / 4;
        ki = (k + 7) / 8;
        e.addr  = {z, w, x};
        e.size  = {16'(k), 16'(n), 16'(m)};
        e.cfg   = {3'(op), 3'(fmt)};
        e.iters = {16'((mi * ki) % 65536), 16'(ki), 16'(ni), 16'(mi)};
        e.lft   = {(n < 4), (k < 8), 8'(m % 4), 8'(n % 4), 8'(k % 8)};
        return e;
    endfunction

    function automatic void clear_staging();
        st_x = '0; st_w = '0; st_z = '0;
        st_m = 0; st_n = 0; st_k = 0; st_op = 0; st_fmt = 0;
    endfunction

    function automatic void apply_write(input logic [2:0] a, input logic [31:0] d);
        case (a)
            3'd0: st_x = d;
            3'd1: st_w = d;
            3'd2: st_z = d;
            3'd3: begin st_m = int'(d[15:0]); st_k = int'(d[31:16]); end
            3'd4: st_n = int'(d[15:0]);
            3'd5: begin st_op = int'(d[12:10]); st_fmt = int'(d[9:7]); end
            default: ;
        endcase
    endfunction

    // One clock: scoreboard any pop happening at this edge, then settle 1 time unit past it.
    task automatic tick();
        if (auto_pop) job_ready_i = 1'($urandom_range(0, 1));
        if (job_valid_o && job_ready_i) begin
            check("pop_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                exp_t e = exp_q.pop_front();
                check("job_addr", job_addr_o, e.addr);
                check("job_size", job_size_o, e.size);
                check("job_cfg", job_cfg_o, e.cfg);
                check("job_iters", job_iters_o, e.iters);
                check("job_lftovr", job_lftovr_o, e.lft);
            end
        end
        @(posedge clk);
        #1;
        if (err_o) err_seen++;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_we_i = 1'b1; reg_addr_i = a; reg_wdata_i = d;
        tick();
        reg_we_i = 1'b0;
        apply_write(a, d);
    endtask

    task automatic load(input logic [31:0] x, w, z, input int m, n, k, op, fmt);
        wr(3'd0, x); wr(3'd1, w); wr(3'd2, z);
        wr(3'd3, {16'(k), 16'(m)});
        wr(3'd4, 32'(n));
        wr(3'd5, (32'(op) << 10) | (32'(fmt) << 7));
    endtask

    task automatic do_commit();
        exp_t e = model(st_x, st_w, st_z, st_m, st_n, st_k, st_op, st_fmt);
        bit ok = (st_m != 0) && (st_n != 0) && (st_k != 0);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        if (ok) exp_q.push_back(e);
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!job_valid_o && n < 60) begin tick(); n++; end
        check(tag, 128'(job_valid_o), 128'(1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 60) begin tick(); n++; end
        check("idle_timeout", 128'(busy_o), 128'(0));
    endtask

    task automatic pop_one();
        job_ready_i = 1'b1;
        tick();
        job_ready_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 128'(job_valid_o), 128'(0));
        check({tag, "_busy"}, 128'(busy_o), 128'(0));
        check({tag, "_err"}, 128'(err_o), 128'(0));
        check({tag, "_cnt"}, 128'(ctx_cnt_o), 128'(0));
        check({tag, "_commit_ready"}, 128'(commit_ready_o), 128'(1));
    endtask

    initial begin
        int  n;
        bit  seen_v;
        exp_t e_old;
        rst_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
        commit_i = 1'b0; job_ready_i = 1'b0;
        clear_staging();
        tick(); tick();
        rst_i = 1'b0;
        check_reset_outputs("reset");

        // Basic job
        load(32'h1000, 32'h2000, 32'h3000, 12, 20, 16, 1, 2);
        do_commit();
        wait_valid("basic_valid", n);
        check("basic_latency", 128'(n), 128'(18));
        check("basic_cnt", 128'(ctx_cnt_o), 128'(1));
        check("basic_iters", 128'(job_iters_o), 128'({16'd6, 16'd2, 16'd5, 16'd3}));
        pop_one();

        // Small sizes
        load(32'h44, 32'h88, 32'hCC, 1, 3, 5, 7, 0);
        do_commit();
        wait_valid("small_valid", n);
        check("small_iters", 128'(job_iters_o), 128'({16'd1, 16'd1, 16'd1, 16'd1}));
        check("small_lft", 128'(job_lftovr_o), 128'({1'b1, 1'b1, 8'd1, 8'd3, 8'd5}));
        pop_one();

        // Zero size: single err pulse, nothing queued
        load(32'h1, 32'h2, 32'h3, 7, 0, 9, 0, 0);
        err_seen = 0;
        do_commit();
        check("zero_err_before_calc", 128'(err_o), 128'(0));
        tick();
        check("zero_err_at_calc", 128'(err_o), 128'(1));
        seen_v = 1'b0;
        for (int i = 0; i < 25; i++) begin tick(); seen_v |= job_valid_o; end
        check("zero_err_pulses", 128'(err_seen), 128'(1));
        check("zero_cnt", 128'(ctx_cnt_o), 128'(0));
        check("zero_no_valid", 128'(seen_v), 128'(0));

        // Full FIFO: third commit ignored, order preserved
        load(32'hA0, 32'hA1, 32'hA2, 8, 8, 8, 1, 1);
        do_commit(); wait_idle();
        load(32'hB0, 32'hB1, 32'hB2, 33, 17, 40, 2, 3);
        do_commit(); wait_idle();
        check("full_cnt", 128'(ctx_cnt_o), 128'(2));
        check("full_commit_ready", 128'(commit_ready_o), 128'(0));
        load(32'hC0, 32'hC1, 32'hC2, 4, 4, 4, 0, 0);
        commit_i = 1'b1; tick(); commit_i = 1'b0; tick();
        check("full_ignored_busy", 128'(busy_o), 128'(0));
        check("full_ignored_cnt", 128'(ctx_cnt_o), 128'(2));
        job_ready_i = 1'b1;
        tick();
        check("full_ready_after_pop", 128'(commit_ready_o), 128'(1));
        check("full_cnt_after_pop", 128'(ctx_cnt_o), 128'(1));
        tick();
        job_ready_i = 1'b0;
        check("full_drained", 128'(ctx_cnt_o), 128'(0));
        check("full_model_empty", 128'(exp_q.size()), 128'(0));

        // Write with commit takes old value; pop during PUSH keeps count
        load(32'hD0, 32'hD1, 32'hD2, 20, 12, 24, 4, 5);
        e_old = model(st_x, st_w, st_z, st_m, st_n, st_k, st_op, st_fmt);
        commit_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = 3'd3; reg_wdata_i = {16'd3, 16'd50};
        tick();
        commit_i = 1'b0; reg_we_i = 1'b0;
        exp_q.push_back(e_old);
        apply_write(3'd3, {16'd3, 16'd50});
        wait_idle();
        do_commit();
        for (int i = 0; i < 17; i++) tick();
        job_ready_i = 1'b1;
        tick();
        job_ready_i = 1'b0;
        check("simul_cnt", 128'(ctx_cnt_o), 128'(1));
        check("simul_head_size", 128'(job_size_o), 128'({16'd3, 16'd12, 16'd50}));
        pop_one();

        // Reset in the middle of MUL
        load(32'h1000, 32'h2000, 32'h3000, 12, 20, 16, 1, 2);
        do_commit();
        for (int i = 0; i < 5; i++) tick();
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        exp_q.delete();
        clear_staging();
        check_reset_outputs("midreset");
        seen_v = 1'b0;
        for (int i = 0; i < 30; i++) begin tick(); seen_v |= job_valid_o; end
        check("midreset_no_job", 128'(seen_v), 128'(0));
        load(32'h1000, 32'h2000, 32'h3000, 12, 20, 16, 1, 2);
        do_commit();
        wait_valid("post_reset_valid", n);
        check("post_reset_latency", 128'(n), 128'(18));
        pop_one();

        // Randomized jobs with random consumer backpressure
        auto_pop = 1'b1;
        for (int j = 0; j < 10; j++) begin
            load($urandom, $urandom, $urandom, $urandom_range(0, 90), $urandom_range(0, 90),
                 $urandom_range(0, 90), $urandom_range(0, 7), $urandom_range(0, 7));
            n = 0;
            while (!commit_ready_o && n < 200) begin tick(); n++; end
            check("rand_commit_ready", 128'(commit_ready_o), 128'(1));
            do_commit();
        end
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 500) begin tick(); n++; end
        auto_pop = 1'b0;
        job_ready_i = 1'b0;
        check("rand_model_empty", 128'(exp_q.size()), 128'(0));
        tick();
        check("rand_fifo_empty", 128'(ctx_cnt_o), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
